// File: rtl/fir_xifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_pkg
// Description : Shared types and constants for the FIR XIFU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_xifu_pkg;

    localparam logic [1:0] INSTR_NONE     = 2'd0;
    localparam logic [1:0] INSTR_XFIRLW   = 2'd1;
    localparam logic [1:0] INSTR_XFIRSW   = 2'd2;
    localparam logic [1:0] INSTR_XFIRDOTP = 2'd3;

    // Stored ID width; the controller's IDW must not exceed it.
    localparam int ENTRY_IDW = 8;

    typedef enum logic [1:0] {
        ENTRY_ISSUED    = 2'd0,
        ENTRY_COMMITTED = 2'd1,
        ENTRY_KILLED    = 2'd2
    } entry_state_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic [ENTRY_IDW-1:0] id;
        logic [1:0]           instr;
        logic [4:0]           rd;
        entry_state_e         state;
    } fir_xifu_ctrl_entry_t;

    function automatic logic writes_rd(input logic [1:0] instr);
        return (instr == INSTR_XFIRLW) || (instr == INSTR_XFIRDOTP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_xifu_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_scoreboard
// Description : Busy bits over XIFU-internal registers with hazard check.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_scoreboard #(
    parameter int NREGS = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_en_i,
    input  logic [4:0] set_rd_i,
    input  logic       kill_en_i,
    input  logic [4:0] kill_rd_i,
    input  logic       wb_en_i,
    input  logic [4:0] wb_rd_i,
    input  logic       chk_rs1_i,
    input  logic       chk_rs2_i,
    input  logic       chk_rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_i,
    output logic       hazard_o
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_d;
    logic [31:0]      w_busy_ext;

    // Set is applied last so it wins over a same-cycle clear.
    always_comb begin
        w_busy_d = r_busy;
        for (int i = 0; i < NREGS; i++) begin
            if ((kill_en_i && kill_rd_i == 5'(i)) || (wb_en_i && wb_rd_i == 5'(i)))
                w_busy_d[i] = 1'b0;
            if (set_en_i && set_rd_i == 5'(i))
                w_busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_busy <= '0;
        else         r_busy <= w_busy_d;
    end

    assign w_busy_ext = 32'(r_busy);
    assign hazard_o   = (chk_rs1_i && w_busy_ext[rs1_i])
                     || (chk_rs2_i && w_busy_ext[rs2_i])
                     || (chk_rd_i  && w_busy_ext[rd_i]);

endmodule
`default_nettype wire

// File: rtl/fir_xifu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_ctrl
// Description : In-order issue/commit/dispatch sequencer for the FIR XIFU.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_ctrl
    import fir_xifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NREGS = 32,
    parameter int IDW   = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           issue_valid_i,
    output logic           issue_ready_o,
    input  logic [IDW-1:0] issue_id_i,
    input  logic [1:0]     issue_instr_i,
    input  logic [4:0]     issue_rd_i,
    input  logic [9:0]     issue_rs_i,
    input  logic           commit_valid_i,
    input  logic [IDW-1:0] commit_id_i,
    input  logic           commit_kill_i,
    output logic           ex_valid_o,
    input  logic           ex_ready_i,
    output logic [IDW-1:0] ex_id_o,
    output logic [1:0]     ex_instr_o,
    output logic [4:0]     ex_rd_o,
    output logic           mem_valid_o,
    input  logic           mem_ready_i,
    input  logic           mem_resp_valid_i,
    input  logic           wb_valid_i,
    input  logic [4:0]     wb_rd_i,
    output logic           busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fir_xifu_ctrl_entry_t r_q [DEPTH];
    logic [PW-1:0]        r_wptr, r_rptr;
    mem_state_e           r_mem_state, w_mem_state_d;

    logic [PW-1:0]        w_count;
    logic                 w_empty, w_full, w_hazard, w_push, w_pop, w_dispatch;
    logic                 w_push_commit, w_mem_pop, w_head_is_mem;
    entry_state_e         w_push_state;
    fir_xifu_ctrl_entry_t w_head;
    logic [DEPTH-1:0]     w_match;
    logic                 w_kill_en;
    logic [4:0]           w_kill_rd;
    logic [AW-1:0]        w_off;

    assign w_count = r_wptr - r_rptr;
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_head  = r_q[r_rptr[AW-1:0]];

    fir_xifu_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .set_en_i  (w_push && writes_rd(issue_instr_i) && !(w_push_commit && commit_kill_i)),
        .set_rd_i  (issue_rd_i),
        .kill_en_i (w_kill_en),
        .kill_rd_i (w_kill_rd),
        .wb_en_i   (wb_valid_i),
        .wb_rd_i   (wb_rd_i),
        .chk_rs1_i (issue_instr_i == INSTR_XFIRSW || issue_instr_i == INSTR_XFIRDOTP),
        .chk_rs2_i (issue_instr_i == INSTR_XFIRDOTP),
        .chk_rd_i  (issue_instr_i == INSTR_XFIRDOTP),
        .rs1_i     (issue_rs_i[4:0]),
        .rs2_i     (issue_rs_i[9:5]),
        .rd_i      (issue_rd_i),
        .hazard_o  (w_hazard)
    );

    assign issue_ready_o = issue_valid_i && !w_full && (issue_instr_i != INSTR_NONE) && !w_hazard;
    assign w_push        = issue_ready_o;
    assign w_push_commit = commit_valid_i && (commit_id_i == issue_id_i);
    assign w_push_state  = !w_push_commit ? ENTRY_ISSUED
                         : (commit_kill_i ? ENTRY_KILLED : ENTRY_COMMITTED);

    // Only occupied ISSUED slots can be committed; occupancy is derived from the pointers.
    always_comb begin
        w_match   = '0;
        w_kill_en = 1'b0;
        w_kill_rd = '0;
        w_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - r_rptr[AW-1:0];
            if (commit_valid_i && ({1'b0, w_off} < w_count)
                && r_q[i].state == ENTRY_ISSUED
                && r_q[i].id == ENTRY_IDW'(commit_id_i)) begin
                w_match[i] = 1'b1;
                if (commit_kill_i && writes_rd(r_q[i].instr)) begin
                    w_kill_en = 1'b1;
                    w_kill_rd = r_q[i].rd;
                end
            end
        end
    end

    assign ex_valid_o    = !w_empty && (w_head.state == ENTRY_COMMITTED) && (r_mem_state == MEM_IDLE);
    assign w_dispatch    = ex_valid_o && ex_ready_i;
    assign w_head_is_mem = (w_head.instr == INSTR_XFIRLW) || (w_head.instr == INSTR_XFIRSW);
    assign ex_id_o       = ex_valid_o ? w_head.id[IDW-1:0] : '0;
    assign ex_instr_o    = ex_valid_o ? w_head.instr : '0;
    assign ex_rd_o       = ex_valid_o ? w_head.rd : '0;

    always_comb begin
        w_mem_state_d = r_mem_state;
        mem_valid_o   = 1'b0;
        w_mem_pop     = 1'b0;
        case (r_mem_state)
            MEM_IDLE: if (w_dispatch && w_head_is_mem) w_mem_state_d = MEM_REQ;
            MEM_REQ: begin
                mem_valid_o = 1'b1;
                if (mem_ready_i) w_mem_state_d = MEM_RESP;
            end
            MEM_RESP: if (mem_resp_valid_i) begin
                w_mem_state_d = MEM_IDLE;
                w_mem_pop     = 1'b1;
            end
            default: w_mem_state_d = MEM_IDLE;
        endcase
    end

    assign w_pop = (!w_empty && w_head.state == ENTRY_KILLED)
                || (w_dispatch && !w_head_is_mem)
                || w_mem_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_mem_state <= MEM_IDLE;
        else         r_mem_state <= w_mem_state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (w_match[i]) r_q[i].state <= commit_kill_i ? ENTRY_KILLED : ENTRY_COMMITTED;
            if (w_push) begin
                r_q[r_wptr[AW-1:0]] <= '{id: ENTRY_IDW'(issue_id_i), instr: issue_instr_i,
                                         rd: issue_rd_i, state: w_push_state};
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
        end
    end

    assign busy_o = !w_empty || (r_mem_state != MEM_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_xifu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_xifu_ctrl
// Description : Directed self-checking bench for fir_xifu_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_xifu_ctrl;

    localparam logic [1:0] NONE = 2'd0, LW = 2'd1, SW = 2'd2, DOTP = 2'd3;

    logic       clk_i, rst_ni;
    logic       issue_valid_i, issue_ready_o;
    logic [3:0] issue_id_i;
    logic [1:0] issue_instr_i;
    logic [4:0] issue_rd_i;
    logic [9:0] issue_rs_i;
    logic       commit_valid_i, commit_kill_i;
    logic [3:0] commit_id_i;
    logic       ex_valid_o, ex_ready_i;
    logic [3:0] ex_id_o;
    logic [1:0] ex_instr_o;
    logic [4:0] ex_rd_o;
    logic       mem_valid_o, mem_ready_i, mem_resp_valid_i;
    logic       wb_valid_i;
    logic [4:0] wb_rd_i;
    logic       busy_o;

    fir_xifu_ctrl #(.DEPTH(4), .NREGS(32), .IDW(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_id_i(issue_id_i), .issue_instr_i(issue_instr_i),
        .issue_rd_i(issue_rd_i), .issue_rs_i(issue_rs_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_id_o(ex_id_o),
        .ex_instr_o(ex_instr_o), .ex_rd_o(ex_rd_o),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .busy_o(busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       valid;
        logic [1:0] instr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       exp_ready;
    } hz_vec_t;

    hz_vec_t vecs [10];
    int      mem_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid_i = 0; issue_id_i = 0; issue_instr_i = NONE; issue_rd_i = 0; issue_rs_i = 0;
        commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
        ex_ready_i = 0; mem_ready_i = 0; mem_resp_valid_i = 0; wb_valid_i = 0; wb_rd_i = 0;
    endtask

    task automatic set_issue(input logic [3:0] id, input logic [1:0] instr, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid_i = 1; issue_id_i = id; issue_instr_i = instr; issue_rd_i = rd;
        issue_rs_i = {rs2, rs1};
    endtask

    task automatic set_commit(input logic [3:0] id, input logic kill);
        commit_valid_i = 1; commit_id_i = id; commit_kill_i = kill;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 0;
        #2;
        rst_ni = 1;
    endtask

    initial begin
        // Reg 7 is busy (uncommitted XFIRLW) while these are probed.
        vecs[0] = '{1'b0, DOTP, 5'd1, 5'd2, 5'd3, 1'b0};
        vecs[1] = '{1'b1, NONE, 5'd1, 5'd2, 5'd3, 1'b0};
        vecs[2] = '{1'b1, LW,   5'd7, 5'd0, 5'd0, 1'b1};
        vecs[3] = '{1'b1, SW,   5'd0, 5'd7, 5'd0, 1'b0};
        vecs[4] = '{1'b1, SW,   5'd0, 5'd6, 5'd7, 1'b1};
        vecs[5] = '{1'b1, DOTP, 5'd1, 5'd2, 5'd7, 1'b0};
        vecs[6] = '{1'b1, DOTP, 5'd7, 5'd2, 5'd3, 1'b0};
        vecs[7] = '{1'b1, DOTP, 5'd1, 5'd7, 5'd3, 1'b0};
        vecs[8] = '{1'b1, DOTP, 5'd1, 5'd2, 5'd3, 1'b1};
        vecs[9] = '{1'b1, SW,   5'd0, 5'd0, 5'd0, 1'b1};

        idle_inputs();
        rst_ni = 0;
        cyc(); cyc();
        check("rst_issue_ready", issue_ready_o, 0);
        check("rst_ex_valid", ex_valid_o, 0);
        check("rst_mem_valid", mem_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ex_id", ex_id_o, 0);
        rst_ni = 1;

        // XFIRDOTP: dispatch one cycle after commit, rd held busy until WB
        cyc(); set_issue(1, DOTP, 3, 1, 2); #3 check("a_issue_ready", issue_ready_o, 1);
        cyc(); issue_valid_i = 0; set_commit(1, 0); ex_ready_i = 1;
        #3 check("a_ex_before_commit", ex_valid_o, 0);
        check("a_busy", busy_o, 1);
        cyc(); commit_valid_i = 0;
        #3 check("a_ex_valid", ex_valid_o, 1);
        check("a_ex_id", ex_id_o, 1);
        check("a_ex_instr", ex_instr_o, DOTP);
        check("a_ex_rd", ex_rd_o, 3);
        cyc(); #3 check("a_ex_after_pop", ex_valid_o, 0);
        check("a_busy_after_pop", busy_o, 0);
        set_issue(7, DOTP, 9, 3, 4); #1 check("a_sb_held", issue_ready_o, 0);
        issue_valid_i = 0; wb_valid_i = 1; wb_rd_i = 3;
        cyc(); wb_valid_i = 0; set_issue(7, DOTP, 9, 3, 4);
        #3 check("a_sb_cleared", issue_ready_o, 1);
        issue_valid_i = 0;
        do_reset();

        // XFIRLW: memory handshake with stalls
        cyc(); set_issue(2, LW, 5, 0, 0); #3 check("b_issue_ready", issue_ready_o, 1);
        cyc(); issue_valid_i = 0; set_commit(2, 0); ex_ready_i = 1;
        cyc(); commit_valid_i = 0;
        #3 check("b_ex_valid", ex_valid_o, 1);
        check("b_ex_instr", ex_instr_o, LW);
        check("b_mem_idle", mem_valid_o, 0);
        mem_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(); mem_ready_i = (k == 3);
            #3 if (mem_valid_o) mem_cnt++;
            check("b_ex_forced_low", ex_valid_o, 0);
        end
        cyc(); mem_ready_i = 0;
        #3 if (mem_valid_o) mem_cnt++;
        check("b_resp_wait_busy", busy_o, 1);
        cyc(); mem_resp_valid_i = 1;
        #3 if (mem_valid_o) mem_cnt++;
        check("b_ex_in_resp", ex_valid_o, 0);
        cyc(); mem_resp_valid_i = 0;
        #3 check("b_busy_after_resp", busy_o, 0);
        check("b_mem_valid_cycles", mem_cnt, 4);
        do_reset();

        // Queue full; a pop does not open the slot in the same cycle
        for (int i = 0; i < 4; i++) begin
            cyc(); set_issue(4'(i), DOTP, 5'(20 + i), 0, 0);
            #3 check("c_fill_ready", issue_ready_o, 1);
        end
        cyc(); set_issue(4, DOTP, 24, 0, 0); set_commit(0, 0); ex_ready_i = 1;
        #3 check("c_full", issue_ready_o, 0);
        cyc(); commit_valid_i = 0;
        #3 check("c_head_ex_valid", ex_valid_o, 1);
        check("c_head_ex_id", ex_id_o, 0);
        check("c_full_during_pop", issue_ready_o, 0);
        cyc(); #3 check("c_ready_after_pop", issue_ready_o, 1);
        cyc(); issue_valid_i = 0; #3 check("c_busy", busy_o, 1);
        do_reset();

        // RAW stall released by a kill
        cyc(); set_issue(5, LW, 7, 0, 0); #3 check("d_issue5", issue_ready_o, 1);
        cyc(); set_issue(6, SW, 0, 7, 0); #3 check("d_stall", issue_ready_o, 0);
        cyc(); set_commit(5, 1); #3 check("d_stall_kill_cycle", issue_ready_o, 0);
        cyc(); commit_valid_i = 0; commit_kill_i = 0;
        #3 check("d_accept", issue_ready_o, 1);
        check("d_killed_no_dispatch", ex_valid_o, 0);
        cyc(); issue_valid_i = 0;
        #3 check("d_ex_idle", ex_valid_o, 0);
        check("d_busy", busy_o, 1);
        do_reset();

        // Hazard table
        cyc(); set_issue(9, LW, 7, 0, 0);
        cyc(); issue_valid_i = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            issue_valid_i = vecs[i].valid; issue_id_i = 4'(10 + i); issue_instr_i = vecs[i].instr;
            issue_rd_i = vecs[i].rd; issue_rs_i = {vecs[i].rs2, vecs[i].rs1};
            #3;
            n_cmp++;
            if (issue_ready_o !== vecs[i].exp_ready) begin
                n_err++;
                $display("FAIL hz_vec[%0d]: got ready=%0b required %0b", i, issue_ready_o, vecs[i].exp_ready);
            end
            issue_valid_i = 0;
        end
        do_reset();

        // Killed head popped, next committed entry dispatched; push+commit same cycle
        cyc(); set_issue(1, DOTP, 1, 0, 0);
        cyc(); set_issue(2, DOTP, 2, 0, 0);
        cyc(); issue_valid_i = 0; set_commit(1, 1); ex_ready_i = 1;
        cyc(); set_commit(2, 0);
        #3 check("f_killed_head", ex_valid_o, 0);
        check("f_busy", busy_o, 1);
        cyc(); commit_valid_i = 0;
        #3 check("f_ex_valid", ex_valid_o, 1);
        check("f_ex_id", ex_id_o, 2);
        cyc(); #3 check("f_empty", busy_o, 0);
        set_issue(3, DOTP, 4, 0, 0); set_commit(3, 0);
        cyc(); issue_valid_i = 0; commit_valid_i = 0;
        #3 check("f_push_commit_ex", ex_valid_o, 1);
        check("f_push_commit_id", ex_id_o, 3);
        do_reset();

        // Reset during RESP with three entries queued
        cyc(); set_issue(1, LW, 1, 0, 0);
        cyc(); set_issue(2, DOTP, 2, 0, 0);
        cyc(); set_issue(3, DOTP, 3, 0, 0);
        cyc(); issue_valid_i = 0; set_commit(1, 0); ex_ready_i = 1;
        cyc(); commit_valid_i = 0; mem_ready_i = 1;
        #3 check("g_ex_valid", ex_valid_o, 1);
        cyc(); #3 check("g_mem_req", mem_valid_o, 1);
        cyc(); mem_ready_i = 0; ex_ready_i = 0;
        #3 check("g_resp_busy", busy_o, 1);
        rst_ni = 0;
        #1 check("g_rst_busy", busy_o, 0);
        check("g_rst_ex_valid", ex_valid_o, 0);
        check("g_rst_mem_valid", mem_valid_o, 0);
        check("g_rst_ex_id", ex_id_o, 0);
        #1 rst_ni = 1;
        cyc(); mem_resp_valid_i = 1;
        #3 check("g_late_resp_busy", busy_o, 0);
        cyc(); mem_resp_valid_i = 0;
        #3 check("g_after_resp_busy", busy_o, 0);
        check("g_after_resp_ex", ex_valid_o, 0);
        set_issue(4, DOTP, 2, 2, 0);
        #1 check("g_sb_cleared", issue_ready_o, 1);
        issue_valid_i = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_xifu_ctrl.md
Name: fir_xifu_ctrl

Overview:
In-order sequencer for the FIR XIFU execute datapath. It accepts offloaded XFIRLW/XFIRSW/XFIRDOTP instructions from the issue interface and tracks them in a small in-flight queue until the core commits or kills them. It holds a busy scoreboard over the XIFU-internal registers and dispatches committed instructions one at a time to the EX stage. For load/store it owns the memory request/response handshake that EX drives.

Parameters:
DEPTH, 4, in-flight queue entries (power of two, 2..8)
NREGS, 32, XIFU-internal registers covered by the scoreboard
IDW, 4, width of the XIF instruction ID

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
issue_valid_i  in  1  offload request valid
issue_ready_o  out  1  request accepted this cycle
issue_id_i  in  IDW  instruction ID
issue_instr_i  in  2  class: 0 NONE, 1 XFIRLW, 2 XFIRSW, 3 XFIRDOTP
issue_rd_i  in  5  internal destination register
issue_rs_i  in  10  internal sources {rs2, rs1}
commit_valid_i  in  1  commit handshake
commit_id_i  in  IDW  committed ID
commit_kill_i  in  1  1 = discard the instruction
ex_valid_o  out  1  dispatch to EX
ex_ready_i  in  1  EX accepts the dispatch
ex_id_o  out  IDW  dispatched ID
ex_instr_o  out  2  dispatched class
ex_rd_o  out  5  dispatched destination register
mem_valid_o  out  1  memory request valid (EX supplies the payload)
mem_ready_i  in  1  memory request accepted
mem_resp_valid_i  in  1  memory response
wb_valid_i  in  1  WB retired the instruction in ex_rd
wb_rd_i  in  5  retired destination register
busy_o  out  1  any entry in flight

Behaviour:
- Reset: rst_ni is asynchronous and active-low; clock is clk_i. All outputs 0, queue empty, scoreboard clear, memory FSM in IDLE.
- Issue acceptance:
  - issue_ready_o is combinational. It is 1 only when issue_valid_i=1, the queue is not full, class is not 0, and no source of the class (XFIRSW: rs1; XFIRDOTP: rs1, rs2, rd) is busy in the scoreboard.
  - On acceptance, the entry is pushed at the tail with state ISSUED. For XFIRLW and XFIRDOTP, scoreboard[rd] is set.
  - Class 0 is never accepted; issue_ready_o=0 for it.
- Commit handling:
  - On commit_valid_i, the matching ISSUED entry becomes COMMITTED, or KILLED if commit_kill_i=1.
  - A killed entry clears its scoreboard bit the same cycle.
  - A commit ID with no match is ignored.
  - A push and a commit of the same ID in the same cycle takes effect: the entry is stored directly as COMMITTED or KILLED.
- Head processing (one entry per cycle):
  - KILLED head: popped without dispatch.
  - COMMITTED head: ex_valid_o=1.
  - Dispatch completes on ex_valid_o & ex_ready_i. XFIRDOTP then pops immediately. XFIRLW/XFIRSW enter the memory FSM instead.
- Memory FSM:
  - IDLE -> REQ on dispatch of a load/store.
  - REQ: mem_valid_o=1 until mem_ready_i.
  - REQ -> RESP on mem_ready_i.
  - RESP -> IDLE on mem_resp_valid_i, which pops the head.
  - ex_valid_o is forced to 0 while not IDLE.
  - Latency: an idle queue with commit in the cycle after issue gives ex_valid_o 1 cycle after commit. The head is visible combinationally, so dispatch may occur the cycle after commit.
- Scoreboard:
  - wb_valid_i clears scoreboard[wb_rd_i].
  - A set and a clear of the same register in the same cycle leaves it set.
- Pointers: read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full is MSBs differ with LSBs equal; empty is all bits equal.
- Simultaneous push and pop when full: the push is rejected, because ready is based on registered full.
- busy_o = queue not empty OR FSM not IDLE.
- Reset mid-operation drops all entries and any memory request; no response is awaited.

Decomposition:
- fir_xifu_pkg:
  - instruction class constants (INSTR_XFIRLW/XFIRSW/XFIRDOTP)
  - fir_xifu_ctrl_entry_t {id, instr, rd, state}
  - entry-state enum {ISSUED, COMMITTED, KILLED}
  - memory FSM enum {MEM_IDLE, MEM_REQ, MEM_RESP}
- Sub-module fir_xifu_scoreboard: NREGS busy bits with set/clear ports and combinational hazard check.

Test Plan:
- Issue XFIRDOTP id=1 rd=3, commit next cycle, ex_ready_i=1 -> ex_valid_o one cycle after commit with id=1; scoreboard[3] stays set until wb_valid_i with rd=3.
- Issue XFIRLW id=2, commit; hold mem_ready_i=0 for 3 cycles, then response after 2 more -> mem_valid_o high 4 cycles, ex_valid_o low throughout, queue pops on response.
- Issue ids 0..3 and then id 4 -> issue_ready_o=0 for id 4 (full); after first pop, id 4 is accepted.
- Issue id=5 rd=7 and id=6 with rs1=7 -> id 6 stalled until id 5 is killed via commit_kill_i; then id 6 is accepted the cycle after.
- Commit id=1 kill, id=2 commit in order -> id 1 is popped with no dispatch, id 2 is dispatched the next cycle.
- Assert rst_ni during RESP with 3 entries queued -> all outputs 0 and busy_o=0 immediately; a later mem_resp_valid_i has no effect.
